// File: rtl/frame_draw_sequencer.sv
// frame_draw_sequencer
//   Per-frame draw controller sitting directly upstream of the black-screen
//   clear stage. On each frame tick it kicks the clear stage, forwards its
//   pixel stream to the VGA write port, then kicks the sprite drawer and
//   forwards its stream, and finally pulses frameDone. It is the sole driver
//   of the VGA adapter plot/x/y/colour inputs.
//
//   Optional feature macro: FRAME_COUNT_EN
//     defined   -> frameCount counts completed frames (wraps 16'hFFFF -> 0)
//     undefined -> no counter is built, frameCount is tied to 16'd0
//
// Ports
//   clk            in   1  system clock
//   resetLow       in   1  synchronous reset, active-low
//   frameTick      in   1  1-cycle pulse, start of frame
//   clearX/Y       in 8/7  pixel coordinates from clear stage
//   clearColorIn   in   3  pixel colour from clear stage
//   clearFinish    in   1  clear stage done (registered level)
//   spriteX/Y      in 8/7  pixel coordinates from sprite drawer
//   spriteColor    in   3  pixel colour from sprite drawer
//   spriteFinish   in   1  sprite drawer done (registered level)
//   clearColorOut  out  3  constant CLEAR_COLOR fed to clear stage
//   clearLoad      out  1  one-cycle enableLoad to clear stage
//   spriteLoad     out  1  one-cycle load to sprite drawer
//   vgaX/Y/Color   out     pixel to VGA adapter (1-cycle latency)
//   plot           out  1  VGA write enable
//   frameDone      out  1  one-cycle pulse, frame fully drawn
//   overrun        out  1  sticky: tick arrived while busy
//   timeout        out  1  sticky: run-state watchdog fired
//   frameCount     out 16  completed frame count (see FRAME_COUNT_EN)

module frame_draw_sequencer #(
  parameter logic [2:0]  CLEAR_COLOR = 3'b000,
  parameter int unsigned MAX_RUN     = 20000
) (
  input  logic        clk,
  input  logic        resetLow,
  input  logic        frameTick,
  input  logic [7:0]  clearX,
  input  logic [6:0]  clearY,
  input  logic [2:0]  clearColorIn,
  input  logic        clearFinish,
  input  logic [7:0]  spriteX,
  input  logic [6:0]  spriteY,
  input  logic [2:0]  spriteColor,
  input  logic        spriteFinish,
  output logic [2:0]  clearColorOut,
  output logic        clearLoad,
  output logic        spriteLoad,
  output logic [7:0]  vgaX,
  output logic [6:0]  vgaY,
  output logic [2:0]  vgaColor,
  output logic        plot,
  output logic        frameDone,
  output logic        overrun,
  output logic        timeout,
  output logic [15:0] frameCount
);

  localparam int unsigned WDW = $clog2(MAX_RUN + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_RUN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_LOAD = 3'd1,
    C_RUN  = 3'd2,
    S_LOAD = 3'd3,
    S_RUN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           pending_q, pending_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [7:0]     vga_x_d;
  logic [6:0]     vga_y_d;
  logic [2:0]     vga_color_d;
  logic           plot_d, clear_load_d, sprite_load_d, frame_done_d;
  logic           overrun_d, timeout_d;

  assign clearColorOut = CLEAR_COLOR;

  // Every registered output is computed from the next state, so load/done
  // strobes are high exactly while the FSM sits in the matching state.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    wd_d          = wd_q;
    vga_x_d       = vgaX;
    vga_y_d       = vgaY;
    vga_color_d   = vgaColor;
    plot_d        = 1'b0;
    clear_load_d  = 1'b0;
    sprite_load_d = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = overrun;
    timeout_d     = timeout;

    // Only one tick is queued; further ticks while busy are dropped.
    if (frameTick && (state_q != IDLE)) begin
      pending_d = 1'b1;
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frameTick || pending_q) begin
          state_d      = C_LOAD;
          pending_d    = 1'b0;
          clear_load_d = 1'b1;
        end
      end
      C_LOAD: begin
        state_d = C_RUN;
        wd_d    = '0;
      end
      C_RUN: begin
        if (clearFinish) begin
          state_d       = S_LOAD;
          sprite_load_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d      = DONE;
          timeout_d    = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          vga_x_d     = clearX;
          vga_y_d     = clearY;
          vga_color_d = clearColorIn;
          plot_d      = 1'b1;
          wd_d        = wd_q + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        if (spriteFinish) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d      = DONE;
          timeout_d    = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          vga_x_d     = spriteX;
          vga_y_d     = spriteY;
          vga_color_d = spriteColor;
          plot_d      = 1'b1;
          wd_d        = wd_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetLow) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      wd_q       <= '0;
      vgaX       <= '0;
      vgaY       <= '0;
      vgaColor   <= '0;
      plot       <= 1'b0;
      clearLoad  <= 1'b0;
      spriteLoad <= 1'b0;
      frameDone  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wd_q       <= wd_d;
      vgaX       <= vga_x_d;
      vgaY       <= vga_y_d;
      vgaColor   <= vga_color_d;
      plot       <= plot_d;
      clearLoad  <= clear_load_d;
      spriteLoad <= sprite_load_d;
      frameDone  <= frame_done_d;
      overrun    <= overrun_d;
      timeout    <= timeout_d;
    end
  end

`ifdef FRAME_COUNT_EN
  // Advances together with the frameDone pulse.
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      frameCount <= '0;
    end else if (frame_done_d) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`else
  assign frameCount = 16'd0;
`endif

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer using small clear/sprite stubs
// (clear stub pixel x = 0,1,2,..., sprite stub pixel x = 100,101,...).
module tb_frame_draw_sequencer;

  logic        clk = 1'b0;
  logic        resetLow;
  logic        frameTick;
  logic [7:0]  clearX, spriteX, vgaX;
  logic [6:0]  clearY, spriteY, vgaY;
  logic [2:0]  clearColorIn, spriteColor, clearColorOut, vgaColor;
  logic        clearFinish, spriteFinish;
  logic        clearLoad, spriteLoad, plot, frameDone, overrun, timeout;
  logic [15:0] frameCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_draw_sequencer #(.CLEAR_COLOR(3'b000), .MAX_RUN(50)) dut (
    .clk(clk), .resetLow(resetLow), .frameTick(frameTick),
    .clearX(clearX), .clearY(clearY), .clearColorIn(clearColorIn),
    .clearFinish(clearFinish),
    .spriteX(spriteX), .spriteY(spriteY), .spriteColor(spriteColor),
    .spriteFinish(spriteFinish),
    .clearColorOut(clearColorOut), .clearLoad(clearLoad), .spriteLoad(spriteLoad),
    .vgaX(vgaX), .vgaY(vgaY), .vgaColor(vgaColor), .plot(plot),
    .frameDone(frameDone), .overrun(overrun), .timeout(timeout),
    .frameCount(frameCount)
  );

  // Stubs: after a load pulse emit N pixels, then raise a registered finish level.
  int unsigned n_clr = 12;
  int unsigned n_spr = 10;
  logic [15:0] clr_idx = '0, spr_idx = '0;
  logic        clr_act = 1'b0, spr_act = 1'b0;
  logic        clr_fin = 1'b0, spr_fin = 1'b0;

  always @(posedge clk) begin
    if (clearLoad) begin
      clr_act <= 1'b1; clr_idx <= '0; clr_fin <= 1'b0;
    end else if (clr_act) begin
      if (32'(clr_idx) == n_clr - 1) begin
        clr_fin <= 1'b1; clr_act <= 1'b0;
      end else clr_idx <= clr_idx + 16'd1;
    end
    if (spriteLoad) begin
      spr_act <= 1'b1; spr_idx <= '0; spr_fin <= 1'b0;
    end else if (spr_act) begin
      if (32'(spr_idx) == n_spr - 1) begin
        spr_fin <= 1'b1; spr_act <= 1'b0;
      end else spr_idx <= spr_idx + 16'd1;
    end
  end

  assign clearX       = clr_idx[7:0];
  assign clearY       = clr_idx[14:8];
  assign clearColorIn = clearColorOut;
  assign clearFinish  = clr_fin;
  assign spriteX      = 8'd100 + spr_idx[7:0];
  assign spriteY      = 7'd5;
  assign spriteColor  = 3'b101;
  assign spriteFinish = spr_fin;

  // Passive monitor: accumulates plotted pixels, pulses and protocol violations.
  int clr_px = 0, clr_sum = 0, spr_px = 0, spr_sum = 0;
  int done_cnt = 0, cload_cnt = 0, viol = 0;

  always @(negedge clk) begin
    if (plot) begin
      if (vgaColor == 3'b000) begin clr_px++; clr_sum += int'(vgaX); end
      else if (vgaColor == 3'b101) begin spr_px++; spr_sum += int'(vgaX); end
    end
    if (frameDone) done_cnt++;
    if (clearLoad) cload_cnt++;
    if ((clearLoad && spriteLoad) || (plot && (clearLoad || spriteLoad || frameDone)))
      viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (frameDone) begin ok = 1'b1; break; end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {clearLoad, spriteLoad, plot, frameDone, overrun, timeout,
                        vgaX, vgaY, vgaColor, clearColorOut}, 32'd0);
    chk({tag, "_cnt"}, 32'(frameCount), 32'd0);
  endtask

  int s_clr_px, s_clr_sum, s_spr_px, s_spr_sum, s_done, s_cload;

  task automatic snap();
    s_clr_px = clr_px; s_clr_sum = clr_sum; s_spr_px = spr_px;
    s_spr_sum = spr_sum; s_done = done_cnt; s_cload = cload_cnt;
  endtask

  initial begin
    resetLow  = 1'b0;
    frameTick = 1'b0;

    // 1. Reset, then idle with no tick.
    step(); step();
    chk_all_zero("rst");
    resetLow = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk_all_zero("idle");

    // 2. One complete frame: 12 clear pixels then 10 sprite pixels.
    snap();
    tick();
    chk("cload_hi", {31'd0, clearLoad}, 32'd1);
    chk("c_load_plot", {30'd0, plot, spriteLoad}, 32'd0);
    step();
    chk("cload_1cyc", {31'd0, clearLoad}, 32'd0);
    step();
    chk("first_px", {23'd0, plot, vgaX}, {23'd0, 1'b1, 8'd0});
    wait_done("f1_done");
    chk("done_plot", {31'd0, plot}, 32'd0);
    step();
    chk("done_1cyc", {31'd0, frameDone}, 32'd0);
    chk("f1_clr_px", 32'(clr_px - s_clr_px), 32'd12);
    chk("f1_clr_sum", 32'(clr_sum - s_clr_sum), 32'd66);
    chk("f1_spr_px", 32'(spr_px - s_spr_px), 32'd10);
    chk("f1_spr_sum", 32'(spr_sum - s_spr_sum), 32'd1045);
    chk("f1_done_n", 32'(done_cnt - s_done), 32'd1);
    chk("f1_flags", {30'd0, overrun, timeout}, 32'd0);

    // 3a. Ticks while busy: one is queued, the extra one dropped.
    snap();
    tick();
    for (int i = 0; i < 5; i++) step();
    tick();
    step();
    tick();
    chk("overrun", {31'd0, overrun}, 32'd1);
    wait_done("f2_done");
    step();
    chk("q_idle", {31'd0, clearLoad}, 32'd0);
    step();
    chk("q_start", {31'd0, clearLoad}, 32'd1);
    wait_done("f3_done");
    for (int i = 0; i < 10; i++) step();
    chk("q_frames", 32'(done_cnt - s_done), 32'd2);
    chk("q_loads", 32'(cload_cnt - s_cload), 32'd2);

    // 3b. Tick landing in the DONE cycle starts the next frame via IDLE.
    tick();
    wait_done("f4_done");
    tick();
    chk("dtick_idle", {31'd0, clearLoad}, 32'd0);
    step();
    chk("dtick_start", {31'd0, clearLoad}, 32'd1);
    wait_done("f5_done");
    step();

    // 4. Clear stage that never finishes: watchdog after 50 run cycles.
    n_clr = 1000;
    snap();
    tick();
    for (int i = 0; i < 50; i++) step();
    chk("wd_pre", {30'd0, plot, timeout}, 32'd2);
    step();
    chk("wd_fire", {29'd0, timeout, frameDone, plot}, 32'd6);
    step();
    chk("wd_sticky", {30'd0, timeout, frameDone}, 32'd2);
    chk("wd_clr_px", 32'(clr_px - s_clr_px), 32'd49);
    chk("wd_spr_px", 32'(spr_px - s_spr_px), 32'd0);
    step(); step();

    // 5. Reset in the middle of the clear run.
    n_clr = 12;
    tick();
    for (int i = 0; i < 4; i++) step();
    chk("mid_px", {23'd0, plot, vgaX}, {23'd0, 1'b1, 8'd2});
    resetLow = 1'b0;
    step();
    chk_all_zero("midrst");
    resetLow = 1'b1;
    snap();
    for (int i = 0; i < 30; i++) step();
    chk("midrst_nodone", 32'(done_cnt - s_done), 32'd0);

    // 6. Three clean frames after reset.
    snap();
    for (int f = 0; f < 3; f++) begin
      tick();
      wait_done("r_done");
      step();
    end
    chk("r_clr_px", 32'(clr_px - s_clr_px), 32'd36);
    chk("r_spr_px", 32'(spr_px - s_spr_px), 32'd30);
`ifdef FRAME_COUNT_EN
    chk("frame_cnt", 32'(frameCount), 32'd3);
`else
    chk("frame_cnt", 32'(frameCount), 32'd0);
`endif
    chk("viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
